// File: rtl/instr_fetch_unit.sv
`timescale 1ns/1ps
// Instruction fetch unit: IDLE/REQ/HOLD FSM feeding decode, with jump/branch PC redirect on handshake.
// Define IFETCH_ILLEGAL_TRAP_EN to compile in the illegal-opcode TRAP state.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        ir_valid,
   input  logic        ir_ready,
   output logic [31:0] instr,
   output logic [5:0]  op,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus4,
   input  logic        jump,
   input  logic [25:0] jump_target,
   input  logic        branch_taken,
   input  logic [15:0] branch_offset,
   output logic        illegal
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
`ifdef IFETCH_ILLEGAL_TRAP_EN
      , TRAP = 2'd3
`endif
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] branch_disp;

`ifdef IFETCH_ILLEGAL_TRAP_EN
   logic op_legal;
   assign op_legal = (imem_rdata[31:26] == 6'h00) || (imem_rdata[31:26] == 6'h23) ||
                     (imem_rdata[31:26] == 6'h02);
`endif

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         instr_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            if (imem_ack) begin
`ifdef IFETCH_ILLEGAL_TRAP_EN
               state_d = op_legal ? HOLD : TRAP;
`else
               state_d = HOLD;
`endif
            end
         end
         HOLD: if (ir_ready) state_d = REQ;
`ifdef IFETCH_ILLEGAL_TRAP_EN
         TRAP: state_d = TRAP;
`endif
         default: state_d = IDLE;
      endcase
   end

   assign branch_disp = {{14{branch_offset[15]}}, branch_offset, 2'b00};

   // Redirect operands matter only on the HOLD handshake; jump wins over branch.
   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      if (state_q == REQ && imem_ack) begin
         instr_d = imem_rdata;
      end
      if (state_q == HOLD && ir_ready) begin
         if (jump)              pc_d = {pc_plus4[31:28], jump_target, 2'b00};
         else if (branch_taken) pc_d = pc_plus4 + branch_disp;
         else                   pc_d = pc_plus4;
      end
   end

   always_comb begin
      imem_req = 1'b0;
      ir_valid = 1'b0;
      illegal  = 1'b0;
      unique case (state_q)
         REQ:  imem_req = 1'b1;
         HOLD: ir_valid = 1'b1;
`ifdef IFETCH_ILLEGAL_TRAP_EN
         TRAP: illegal  = 1'b1;
`endif
         default: ;
      endcase
   end

   assign imem_addr = pc_q;
   assign pc_out    = pc_q;
   assign pc_plus4  = pc_q + 32'd4;
   assign instr     = instr_q;
   assign op        = instr_q[31:26];

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be the synchronous, active-high reset, sampled only on the rising edge of clk.
REQ-004 imem_req  output  1  SHALL be the instruction-memory read request.
REQ-005 imem_addr  output  32  SHALL be the word-aligned read address, equal to the current PC.
REQ-006 imem_ack  input  1  SHALL indicate that imem_rdata is valid in this cycle.
REQ-007 imem_rdata  input  32  SHALL be the instruction word returned by memory.
REQ-008 ir_valid  output  1  SHALL indicate that instr, op, pc_out and pc_plus4 hold a fetched instruction for decode.
REQ-009 ir_ready  input  1  SHALL indicate that decode accepts the instruction this cycle.
REQ-010 instr  output  32  SHALL be the instruction register.
REQ-011 op  output  6  SHALL equal instr[31:26].
REQ-012 pc_out  output  32  SHALL be the address of instr.
REQ-013 pc_plus4  output  32  SHALL equal pc_out + 4, modulo 2^32.
REQ-014 jump  input  1  SHALL be the decode jump indication, with target jump_target  input  26.
REQ-015 branch_taken  input  1  SHALL be the resolved branch indication, with branch_offset  input  16 (signed word offset).
REQ-016 illegal  output  1  SHALL be the illegal-opcode trap flag.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, REQ, HOLD and TRAP.
REQ-018 IDLE SHALL last one cycle and then go to REQ, with imem_req=0 and ir_valid=0.
REQ-019 In REQ, imem_req SHALL be 1, and imem_addr SHALL stay stable until the cycle in which imem_ack=1.
REQ-020 In REQ with imem_ack=1, the unit SHALL load imem_rdata into instr and go to HOLD; imem_req SHALL be 0 in the following cycle.
REQ-021 imem_ack in any state other than REQ SHALL be ignored.
REQ-022 Fetch latency SHALL be 1 cycle: ir_valid rises on the edge after the imem_ack cycle; peak throughput SHALL be one instruction per 2 cycles.
REQ-023 In HOLD, ir_valid SHALL be 1, and instr, op, pc_out and pc_plus4 SHALL stay stable until ir_ready=1.
REQ-024 On the handshake cycle (HOLD, ir_valid=1, ir_ready=1), the next PC SHALL be set as follows, and the FSM SHALL go to REQ:
- jump=1: PC = {pc_plus4[31:28], jump_target, 2'b00}.
- else branch_taken=1: PC = pc_plus4 + (sign-extended branch_offset << 2).
- else: PC = pc_plus4.
REQ-025 jump SHALL take priority over branch_taken when both are 1.
REQ-026 jump, branch_taken and their operands SHALL be sampled only on the handshake cycle.
REQ-027 All PC arithmetic SHALL wrap modulo 2^32 with no overflow indication.

Reset
REQ-028 When reset=1 at a clock edge, the following SHALL be loaded: state=IDLE, PC=RESET_PC, instr=0, imem_req=0, ir_valid=0, illegal=0.
REQ-029 Reset SHALL take priority over every other input, including an imem_ack in the same cycle or a handshake in the same cycle.
REQ-030 A reset asserted during a pending REQ SHALL abandon the request; that request's data SHALL never appear on instr.

Configuration
REQ-031 The macro IFETCH_ILLEGAL_TRAP_EN SHALL select whether illegal-opcode trapping is compiled in.
REQ-032 With IFETCH_ILLEGAL_TRAP_EN defined:
- The legal op values SHALL be 6'h00, 6'h23 and 6'h02.
- A fetched instruction with any other op SHALL go to TRAP instead of HOLD.
- In TRAP: illegal=1, ir_valid=0, imem_req=0; instr and pc_out SHALL hold the offending word and address.
- TRAP SHALL persist until reset.
REQ-033 Without IFETCH_ILLEGAL_TRAP_EN, illegal SHALL be constant 0, every op SHALL be forwarded through HOLD, and the TRAP state SHALL be absent.

Verification
REQ-034 Reset with RESET_PC=0 and imem_ack tied to 1 -> imem_addr sequence 0x0, 0x4, 0x8, with ir_valid high every second cycle.
REQ-035 imem_ack delayed 3 cycles -> imem_req held high and imem_addr held stable for 4 cycles, then instr = imem_rdata.
REQ-036 ir_ready held low for 5 cycles -> ir_valid, instr and pc_out stable for 5 cycles; no new imem_req is issued.
REQ-037 PC=0x0000_0010, handshake with jump=1, jump_target=26'h40, branch_taken=1 -> next imem_addr = 0x0000_0100.
REQ-038 PC=0x0000_0020, handshake with branch_taken=1, branch_offset=16'hFFFE -> next imem_addr = 0x0000_001C; PC=0xFFFF_FFFC, no redirect -> next imem_addr = 0x0000_0000.
REQ-039 With IFETCH_ILLEGAL_TRAP_EN defined, fetch 32'hFC00_0000 -> illegal=1 and ir_valid=0 until reset; reset pulse during REQ with imem_ack=1 in the same cycle -> state IDLE, instr=0.
